// File: rtl/csr_commit_pipe_pkg.sv
// csr_commit_pipe_pkg
// Shared widths, exception codes and stage payload types for the CSR commit
// pipeline. Exception code values match the core-wide define file.
package csr_commit_pipe_pkg;

   localparam int DATA_W      = 32;
   localparam int EXCEPTION_W = 6;

   typedef logic [EXCEPTION_W-1:0] exc_code_t;

   localparam exc_code_t EXCEPTION_NONE                = 6'h00;
   localparam exc_code_t EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
   localparam exc_code_t EXCEPTION_ECALL_M             = 6'h1b;
   localparam exc_code_t EXCEPTION_INTERRUPT           = 6'h20;
   localparam exc_code_t EXCEPTION_FENCE               = 6'h31;

   // Instruction metadata captured at issue.
   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [31:0]       opcode;
      logic [4:0]        rd_idx;
   } e1_payload_t;

   // Metadata paired with the CSR unit's registered E1 result.
   typedef struct packed {
      e1_payload_t       meta;
      logic [DATA_W-1:0] value;
      logic              write;
      logic [DATA_W-1:0] wdata;
      exc_code_t         exception;
   } e2_payload_t;

   // Fully merged commit record; write permissions are resolved before WB so
   // the outputs only need valid/stall gating.
   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [4:0]        rd_idx;
      logic [11:0]       waddr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] value;
      exc_code_t         exception;
      logic [DATA_W-1:0] tval;
      logic              csr_write;
      logic              rf_write;
   } wb_payload_t;

   typedef struct packed {
      exc_code_t         code;
      logic [DATA_W-1:0] tval;
   } exc_info_t;

endpackage

// File: rtl/csr_commit_pipe_reg.sv
// csr_pipe_reg
// One pipeline stage: payload register with a valid bit.
//   clk_i, rst_i : clock, synchronous active-high reset (clears valid and data)
//   stall_i      : hold valid and data
//   kill_i       : drop this stage's contents; also blocks capture of new data
//   valid_i      : incoming valid (already qualified by upstream kills)
//   data_i       : incoming payload
//   valid_o      : stage valid
//   data_o       : stage payload (only updated when a valid entry is captured)
module csr_pipe_reg #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         stall_i,
   input  logic         kill_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (stall_i) begin
         // A kill still lands while frozen so a redirect is never lost.
         valid_o <= valid_o & ~kill_i;
      end else begin
         valid_o <= valid_i & ~kill_i;
         if (valid_i && !kill_i) begin
            data_o <= data_i;
         end
      end
   end

endmodule

// File: rtl/csr_commit_pipe.sv
// csr_commit_pipe
// Tracks issued instructions through E1 -> E2 -> WB, merges CSR, interrupt and
// LSU exceptions at E2, and presents the CSR-file and integer-regfile commit
// bundle from WB flops. Younger instructions are killed behind an exception.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   stall_i, squash_i          : freeze all stages / kill E1 and E2
//   take_interrupt_i           : pending interrupt, applied to the E2 instruction
//   opcode_*_i                 : issue-stage instruction (valid, word, pc, rd)
//   csr_result_e1_*_i          : CSR unit result for the instruction in E1
//   mem_exception_i, mem_addr_i: LSU fault for the instruction in E2
//   csr_writeback_*_o          : CSR register file commit bundle
//   wb_valid_o, wb_rd_idx_o, wb_value_o : integer regfile write
module csr_commit_pipe
   import csr_commit_pipe_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   squash_i,
   input  logic                   take_interrupt_i,
   input  logic                   opcode_valid_i,
   input  logic [31:0]            opcode_opcode_i,
   input  logic [DATA_W-1:0]      opcode_pc_i,
   input  logic [4:0]             opcode_rd_idx_i,
   input  logic [DATA_W-1:0]      csr_result_e1_value_i,
   input  logic                   csr_result_e1_write_i,
   input  logic [DATA_W-1:0]      csr_result_e1_wdata_i,
   input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
   input  logic [EXCEPTION_W-1:0] mem_exception_i,
   input  logic [DATA_W-1:0]      mem_addr_i,
   output logic                   csr_writeback_write_o,
   output logic [11:0]            csr_writeback_waddr_o,
   output logic [DATA_W-1:0]      csr_writeback_wdata_o,
   output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
   output logic [DATA_W-1:0]      csr_writeback_exception_pc_o,
   output logic [DATA_W-1:0]      csr_writeback_exception_addr_o,
   output logic                   wb_valid_o,
   output logic [4:0]             wb_rd_idx_o,
   output logic [DATA_W-1:0]      wb_value_o
);

   // Priority: interrupt, then CSR exception, then LSU fault.
   function automatic exc_info_t merge_exception(
      input logic              irq,
      input exc_code_t         csr_exc,
      input logic [DATA_W-1:0] csr_value,
      input exc_code_t         mem_exc,
      input logic [DATA_W-1:0] mem_addr
   );
      exc_info_t r;
      r.code = EXCEPTION_NONE;
      r.tval = '0;
      if (irq) begin
         r.code = EXCEPTION_INTERRUPT;
      end else if (csr_exc != EXCEPTION_NONE) begin
         r.code = csr_exc;
         // On an illegal instruction the CSR unit returns the opcode as value.
         if (csr_exc == EXCEPTION_ILLEGAL_INSTRUCTION) begin
            r.tval = csr_value;
         end
      end else if (mem_exc != EXCEPTION_NONE) begin
         r.code = mem_exc;
         r.tval = mem_addr;
      end
      return r;
   endfunction

   e1_payload_t e1_in, e1_p0;
   e2_payload_t e2_in, e2_p1;
   wb_payload_t wb_in, wb_p2;
   logic        vld_p0, vld_p1, vld_p2;
   exc_info_t   exc_e2;
   logic        csr_ok_e2;
   logic        wb_exc_p2;
   logic        kill_e1, kill_e2;
   logic        unused_opcode_low;

   // Issue -> E1
   assign e1_in = '{pc: opcode_pc_i, opcode: opcode_opcode_i, rd_idx: opcode_rd_idx_i};

   csr_pipe_reg #(.W($bits(e1_payload_t))) u_e1 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .kill_i  (kill_e1),
      .valid_i (opcode_valid_i),
      .data_i  (e1_in),
      .valid_o (vld_p0),
      .data_o  (e1_p0)
   );

   // E1 -> E2: the CSR unit's result is already aligned with E1.
   assign e2_in = '{meta:      e1_p0,
                    value:     csr_result_e1_value_i,
                    write:     csr_result_e1_write_i,
                    wdata:     csr_result_e1_wdata_i,
                    exception: csr_result_e1_exception_i};

   csr_pipe_reg #(.W($bits(e2_payload_t))) u_e2 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .kill_i  (kill_e2),
      .valid_i (vld_p0 & ~kill_e1),
      .data_i  (e2_in),
      .valid_o (vld_p1),
      .data_o  (e2_p1)
   );

   // E2 merge -> WB
   assign exc_e2 = merge_exception(take_interrupt_i & vld_p1, e2_p1.exception,
                                   e2_p1.value, mem_exception_i, mem_addr_i);
   assign csr_ok_e2 = e2_p1.write & (exc_e2.code == EXCEPTION_NONE);

   assign wb_in = '{pc:        e2_p1.meta.pc,
                    rd_idx:    e2_p1.meta.rd_idx,
                    waddr:     e2_p1.meta.opcode[31:20],
                    wdata:     e2_p1.wdata,
                    value:     e2_p1.value,
                    exception: exc_e2.code,
                    tval:      exc_e2.tval,
                    csr_write: csr_ok_e2,
                    rf_write:  csr_ok_e2 & (e2_p1.meta.rd_idx != 5'd0)};

   assign unused_opcode_low = ^e2_p1.meta.opcode[19:0];

   // Everything younger than an excepting instruction is dropped: an E2
   // exception kills E1, a WB exception kills E1 and E2.
   assign wb_exc_p2 = vld_p2 & (wb_p2.exception != EXCEPTION_NONE);
   assign kill_e2   = squash_i | wb_exc_p2;
   assign kill_e1   = kill_e2 | (vld_p1 & (exc_e2.code != EXCEPTION_NONE));

   csr_pipe_reg #(.W($bits(wb_payload_t))) u_wb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .kill_i  (1'b0),
      .valid_i (vld_p1 & ~kill_e2),
      .data_i  (wb_in),
      .valid_o (vld_p2),
      .data_o  (wb_p2)
   );

   // WB outputs: strobes are masked while stalled so the held entry is
   // presented exactly once, in the cycle the stall releases.
   assign csr_writeback_write_o          = vld_p2 & wb_p2.csr_write & ~stall_i;
   assign csr_writeback_waddr_o          = wb_p2.waddr;
   assign csr_writeback_wdata_o          = wb_p2.wdata;
   assign csr_writeback_exception_o      = (vld_p2 && !stall_i) ? wb_p2.exception : EXCEPTION_NONE;
   assign csr_writeback_exception_pc_o   = vld_p2 ? wb_p2.pc   : '0;
   assign csr_writeback_exception_addr_o = vld_p2 ? wb_p2.tval : '0;
   assign wb_valid_o                     = vld_p2 & wb_p2.rf_write & ~stall_i;
   assign wb_rd_idx_o                    = wb_p2.rd_idx;
   assign wb_value_o                     = wb_p2.value;

endmodule
